// File: rtl/params_pkg.sv
// Shared widths and types for the memory-side blocks.
// No logic; type and parameter definitions only.
// Consumed by mem_arbiter and its bench.
package params_pkg;

    parameter int ADDR_WIDTH = 32;
    parameter int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } access_size_t;

    typedef logic [31:0] instruction_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one single-outstanding memory port.
// Latency: request issued 1 cycle after capture in IDLE; response routed 1 cycle after mem_resp_valid_i.
// Backpressure: each requester holds one pending entry; no pulse again until its response.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = params_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH   = params_pkg::DATA_WIDTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       if_req_valid_i,
    input  logic [ADDR_WIDTH-1:0]      if_req_addr_i,
    input  params_pkg::access_size_t   if_req_size_i,
    output logic                       if_resp_valid_o,
    output params_pkg::instruction_t   if_resp_data_o,
    input  logic                       d_req_valid_i,
    input  logic                       d_req_we_i,
    input  logic [ADDR_WIDTH-1:0]      d_req_addr_i,
    input  logic [DATA_WIDTH-1:0]      d_req_wdata_i,
    input  params_pkg::access_size_t   d_req_size_i,
    output logic                       d_resp_valid_o,
    output logic [DATA_WIDTH-1:0]      d_resp_data_o,
    output logic                       d_busy_o,
    output logic                       mem_req_valid_o,
    output logic                       mem_req_we_o,
    output logic [ADDR_WIDTH-1:0]      mem_req_addr_o,
    output logic [DATA_WIDTH-1:0]      mem_req_wdata_o,
    output params_pkg::access_size_t   mem_req_size_o,
    input  logic                       mem_resp_valid_i,
    input  logic [DATA_WIDTH-1:0]      mem_resp_data_i,
    output logic                       spurious_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_D_BUSY  = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t                   state_q, state_d;

    logic                     if_pend_q, if_pend_d;
    logic [ADDR_WIDTH-1:0]    if_pend_addr_q, if_pend_addr_d;
    params_pkg::access_size_t if_pend_size_q, if_pend_size_d;

    logic                     d_pend_q, d_pend_d;
    logic                     d_pend_we_q, d_pend_we_d;
    logic [ADDR_WIDTH-1:0]    d_pend_addr_q, d_pend_addr_d;
    logic [DATA_WIDTH-1:0]    d_pend_wdata_q, d_pend_wdata_d;
    params_pkg::access_size_t d_pend_size_q, d_pend_size_d;

    logic [3:0]               starve_q, starve_d;

    logic                     mem_req_valid_q, mem_req_valid_d;
    logic                     mem_req_we_q, mem_req_we_d;
    logic [ADDR_WIDTH-1:0]    mem_req_addr_q, mem_req_addr_d;
    logic [DATA_WIDTH-1:0]    mem_req_wdata_q, mem_req_wdata_d;
    params_pkg::access_size_t mem_req_size_q, mem_req_size_d;

    logic                     if_resp_valid_q, if_resp_valid_d;
    params_pkg::instruction_t if_resp_data_q, if_resp_data_d;
    logic                     d_resp_valid_q, d_resp_valid_d;
    logic [DATA_WIDTH-1:0]    d_resp_data_q, d_resp_data_d;
    logic                     d_busy_q, d_busy_d;
    logic                     spurious_q, spurious_d;

    // A request arriving this cycle competes alongside one already pending.
    logic                     if_avail, d_avail, fetch_wins;

    // Next-state: pending capture, arbitration in IDLE, response routing in BUSY.
    always_comb begin
        state_d         = state_q;
        if_pend_d       = if_pend_q;
        if_pend_addr_d  = if_pend_addr_q;
        if_pend_size_d  = if_pend_size_q;
        d_pend_d        = d_pend_q;
        d_pend_we_d     = d_pend_we_q;
        d_pend_addr_d   = d_pend_addr_q;
        d_pend_wdata_d  = d_pend_wdata_q;
        d_pend_size_d   = d_pend_size_q;
        starve_d        = starve_q;
        mem_req_valid_d = 1'b0;
        mem_req_we_d    = mem_req_we_q;
        mem_req_addr_d  = mem_req_addr_q;
        mem_req_wdata_d = mem_req_wdata_q;
        mem_req_size_d  = mem_req_size_q;
        if_resp_valid_d = 1'b0;
        if_resp_data_d  = '0;
        d_resp_valid_d  = 1'b0;
        d_resp_data_d   = '0;
        spurious_d      = spurious_q;

        // Capture new pulses; a grant below in the same cycle clears them again.
        if (if_req_valid_i) begin
            if_pend_d      = 1'b1;
            if_pend_addr_d = if_req_addr_i;
            if_pend_size_d = if_req_size_i;
        end
        if (d_req_valid_i) begin
            d_pend_d       = 1'b1;
            d_pend_we_d    = d_req_we_i;
            d_pend_addr_d  = d_req_addr_i;
            d_pend_wdata_d = d_req_wdata_i;
            d_pend_size_d  = d_req_size_i;
        end

        if_avail   = if_pend_q | if_req_valid_i;
        d_avail    = d_pend_q | d_req_valid_i;
        fetch_wins = if_avail & (~d_avail | (starve_q == STARVE_MAX));

        case (state_q)
            ST_IDLE: begin
                // Nothing is outstanding, so any response now is unexpected.
                if (mem_resp_valid_i) begin
                    spurious_d = 1'b1;
                end
                if (fetch_wins) begin
                    mem_req_valid_d = 1'b1;
                    mem_req_we_d    = 1'b0;
                    mem_req_addr_d  = if_pend_addr_d;
                    mem_req_wdata_d = '0;
                    mem_req_size_d  = if_pend_size_d;
                    if_pend_d       = 1'b0;
                    starve_d        = '0;
                    state_d         = ST_IF_BUSY;
                end else if (d_avail) begin
                    mem_req_valid_d = 1'b1;
                    mem_req_we_d    = d_pend_we_d;
                    mem_req_addr_d  = d_pend_addr_d;
                    mem_req_wdata_d = d_pend_wdata_d;
                    mem_req_size_d  = d_pend_size_d;
                    d_pend_d        = 1'b0;
                    if (if_avail && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + 4'd1;
                    end
                    state_d = ST_D_BUSY;
                end
            end
            ST_IF_BUSY: begin
                if (mem_resp_valid_i) begin
                    if_resp_valid_d = 1'b1;
                    if_resp_data_d  = params_pkg::instruction_t'(mem_resp_data_i);
                    state_d         = ST_IDLE;
                end
            end
            ST_D_BUSY: begin
                if (mem_resp_valid_i) begin
                    d_resp_valid_d = 1'b1;
                    d_resp_data_d  = mem_req_we_q ? '0 : mem_resp_data_i;
                    state_d        = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Busy covers waiting, in flight, and the response delivery cycle.
        d_busy_d = d_pend_d | (state_d == ST_D_BUSY) | d_resp_valid_d;
    end

    // State and registered outputs; reset drops any outstanding access.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q         <= ST_IDLE;
            if_pend_q       <= 1'b0;
            if_pend_addr_q  <= '0;
            if_pend_size_q  <= params_pkg::SIZE_BYTE;
            d_pend_q        <= 1'b0;
            d_pend_we_q     <= 1'b0;
            d_pend_addr_q   <= '0;
            d_pend_wdata_q  <= '0;
            d_pend_size_q   <= params_pkg::SIZE_BYTE;
            starve_q        <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_we_q    <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_wdata_q <= '0;
            mem_req_size_q  <= params_pkg::SIZE_BYTE;
            if_resp_valid_q <= 1'b0;
            if_resp_data_q  <= '0;
            d_resp_valid_q  <= 1'b0;
            d_resp_data_q   <= '0;
            d_busy_q        <= 1'b0;
            spurious_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            if_pend_q       <= if_pend_d;
            if_pend_addr_q  <= if_pend_addr_d;
            if_pend_size_q  <= if_pend_size_d;
            d_pend_q        <= d_pend_d;
            d_pend_we_q     <= d_pend_we_d;
            d_pend_addr_q   <= d_pend_addr_d;
            d_pend_wdata_q  <= d_pend_wdata_d;
            d_pend_size_q   <= d_pend_size_d;
            starve_q        <= starve_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_we_q    <= mem_req_we_d;
            mem_req_addr_q  <= mem_req_addr_d;
            mem_req_wdata_q <= mem_req_wdata_d;
            mem_req_size_q  <= mem_req_size_d;
            if_resp_valid_q <= if_resp_valid_d;
            if_resp_data_q  <= if_resp_data_d;
            d_resp_valid_q  <= d_resp_valid_d;
            d_resp_data_q   <= d_resp_data_d;
            d_busy_q        <= d_busy_d;
            spurious_q      <= spurious_d;
        end
    end

    assign if_resp_valid_o = if_resp_valid_q;
    assign if_resp_data_o  = if_resp_data_q;
    assign d_resp_valid_o  = d_resp_valid_q;
    assign d_resp_data_o   = d_resp_data_q;
    assign d_busy_o        = d_busy_q;
    assign mem_req_valid_o = mem_req_valid_q;
    assign mem_req_we_o    = mem_req_we_q;
    assign mem_req_addr_o  = mem_req_addr_q;
    assign mem_req_wdata_o = mem_req_wdata_q;
    assign mem_req_size_o  = mem_req_size_q;
    assign spurious_o      = spurious_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction table, directed corner sequences, randomized traffic.
// Outputs sampled 1 time unit after the rising edge; inputs driven at the same point.
// Memory side modelled by the bench with a random 0..3 cycle response delay.
module tb_mem_arbiter;
    import params_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SL = 4;

    logic clk_i = 1'b0;
    logic rst_i;
    logic if_req_valid_i;
    logic [AW-1:0] if_req_addr_i;
    access_size_t if_req_size_i;
    logic if_resp_valid_o;
    instruction_t if_resp_data_o;
    logic d_req_valid_i, d_req_we_i;
    logic [AW-1:0] d_req_addr_i;
    logic [DW-1:0] d_req_wdata_i;
    access_size_t d_req_size_i;
    logic d_resp_valid_o;
    logic [DW-1:0] d_resp_data_o;
    logic d_busy_o;
    logic mem_req_valid_o, mem_req_we_o;
    logic [AW-1:0] mem_req_addr_o;
    logic [DW-1:0] mem_req_wdata_o;
    access_size_t mem_req_size_o;
    logic mem_resp_valid_i;
    logic [DW-1:0] mem_resp_data_i;
    logic spurious_o;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_valid_i(if_req_valid_i), .if_req_addr_i(if_req_addr_i), .if_req_size_i(if_req_size_i),
        .if_resp_valid_o(if_resp_valid_o), .if_resp_data_o(if_resp_data_o),
        .d_req_valid_i(d_req_valid_i), .d_req_we_i(d_req_we_i), .d_req_addr_i(d_req_addr_i),
        .d_req_wdata_i(d_req_wdata_i), .d_req_size_i(d_req_size_i),
        .d_resp_valid_o(d_resp_valid_o), .d_resp_data_o(d_resp_data_o), .d_busy_o(d_busy_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_req_wdata_o(mem_req_wdata_o), .mem_req_size_o(mem_req_size_o),
        .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_data_i(mem_resp_data_i),
        .spurious_o(spurious_o)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr_in();
        if_req_valid_i   = 1'b0;
        if_req_addr_i    = '0;
        if_req_size_i    = SIZE_BYTE;
        d_req_valid_i    = 1'b0;
        d_req_we_i       = 1'b0;
        d_req_addr_i     = '0;
        d_req_wdata_i    = '0;
        d_req_size_i     = SIZE_BYTE;
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i  = '0;
    endtask

    task automatic pulse_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        d_req_valid_i = 1'b1;
        d_req_we_i    = we;
        d_req_addr_i  = addr;
        d_req_wdata_i = wdata;
        d_req_size_i  = SIZE_WORD;
    endtask

    task automatic pulse_if(input logic [31:0] addr);
        if_req_valid_i = 1'b1;
        if_req_addr_i  = addr;
        if_req_size_i  = SIZE_WORD;
    endtask

    // Everything observable must be zero while reset is held.
    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_req_valid"}, mem_req_valid_o, 0);
        chk({tag, "_mem_req_we"},    mem_req_we_o, 0);
        chk({tag, "_mem_req_addr"},  mem_req_addr_o, 0);
        chk({tag, "_mem_req_wdata"}, mem_req_wdata_o, 0);
        chk({tag, "_if_resp_valid"}, if_resp_valid_o, 0);
        chk({tag, "_d_resp_valid"},  d_resp_valid_o, 0);
        chk({tag, "_d_busy"},        d_busy_o, 0);
        chk({tag, "_spurious"},      spurious_o, 0);
    endtask

    // One starvation round: fetch and data arrive together, data re-requests as soon
    // as each load completes; counts data grants issued before the fetch grant.
    task automatic starve_round(output int n_data, output logic fetch_we);
        bit got_fetch;
        got_fetch = 1'b0;
        n_data    = 0;
        fetch_we  = 1'b1;
        clr_in();
        pulse_if(32'h100);
        pulse_d(1'b0, 32'h200, 32'h0);
        for (int b = 0; b < 40 && !got_fetch; b++) begin
            step();
            clr_in();
            if (mem_req_valid_o) begin
                mem_resp_valid_i = 1'b1;
                mem_resp_data_i  = 32'h1000 + 32'(b);
                if (mem_req_addr_o == 32'h100) begin
                    got_fetch = 1'b1;
                    fetch_we  = mem_req_we_o;
                end else begin
                    n_data++;
                end
            end
            if (d_resp_valid_o && !got_fetch) begin
                pulse_d(1'b0, 32'h200 + 32'(b), 32'h0);
            end
        end
        if (!got_fetch) chk("starve_fetch_timeout", 0, 1);
        for (int k = 0; k < 8; k++) begin
            step();
            clr_in();
            if (mem_req_valid_o) begin
                mem_resp_valid_i = 1'b1;
                mem_resp_data_i  = 32'h77;
            end
        end
        step();
        clr_in();
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic [31:0] rdata;
        logic        exp_we;
        logic [31:0] exp_rdata;
    } vec_t;

    // Reference model state for randomized traffic.
    bit            m_free, w_if, w_d, w_d_we, owner_we, dflag;
    logic [31:0]   w_if_addr, w_d_addr, w_d_wdata;
    access_size_t  w_if_size, w_d_size;
    int            starve, owner;
    bit            e_req_v, e_req_we, e_ifr, e_dr, e_busy;
    logic [31:0]   e_req_addr, e_req_wdata, e_rdata;
    access_size_t  e_req_size;
    bit            if_out, d_out, mem_pend, a_if, a_d, resp_now;
    int            mem_cnt;

    initial begin
        vec_t vecs[5];
        vec_t v;
        int   nd;
        logic fwe;

        vecs[0] = '{1'b0, 1'b0, 32'h10,       32'h0,        2'd2, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b0, 32'h40,       32'h0,        2'd2, 32'h12345678, 1'b0, 32'h12345678};
        vecs[2] = '{1'b1, 1'b1, 32'h44,       32'hA5A5A5A5, 2'd0, 32'hFFFFFFFF, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 32'hFFFFFFFC, 32'h0,        2'd2, 32'h00000000, 1'b0, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 32'h0,        32'h0,        2'd1, 32'h80000001, 1'b0, 32'h80000001};

        rst_i = 1'b0;
        clr_in();
        #12;
        chk_all_zero("reset");
        rst_i = 1'b1;
        step();

        // Isolated transactions with fixed 2-cycle memory latency.
        for (int i = 0; i < 5; i++) begin
            v = vecs[i];
            if (v.is_d) begin
                d_req_valid_i = 1'b1; d_req_we_i = v.we; d_req_addr_i = v.addr;
                d_req_wdata_i = v.wdata; d_req_size_i = access_size_t'(v.size);
            end else begin
                if_req_valid_i = 1'b1; if_req_addr_i = v.addr; if_req_size_i = access_size_t'(v.size);
            end
            chk("vec_busy_c0", d_busy_o, 0);
            step(); clr_in();
            chk("vec_req_valid", mem_req_valid_o, 1);
            chk("vec_req_addr", mem_req_addr_o, v.addr);
            chk("vec_req_we", mem_req_we_o, v.exp_we);
            chk("vec_req_size", mem_req_size_o, v.size);
            if (v.exp_we) chk("vec_req_wdata", mem_req_wdata_o, v.wdata);
            chk("vec_busy_c1", d_busy_o, v.is_d);
            step();
            chk("vec_req_single", mem_req_valid_o, 0);
            chk("vec_req_addr_hold", mem_req_addr_o, v.addr);
            step();
            mem_resp_valid_i = 1'b1; mem_resp_data_i = v.rdata;
            chk("vec_no_early_resp", if_resp_valid_o | d_resp_valid_o, 0);
            step(); clr_in();
            chk("vec_if_resp_valid", if_resp_valid_o, !v.is_d);
            chk("vec_d_resp_valid", d_resp_valid_o, v.is_d);
            if (v.is_d) chk("vec_d_resp_data", d_resp_data_o, v.exp_rdata);
            else        chk("vec_if_resp_data", if_resp_data_o, v.exp_rdata);
            chk("vec_busy_c4", d_busy_o, v.is_d);
            step();
            chk("vec_resp_single", if_resp_valid_o | d_resp_valid_o, 0);
            chk("vec_busy_c5", d_busy_o, 0);
        end

        // Simultaneous fetch and store: store first, fetch after the store response.
        pulse_if(32'h20);
        pulse_d(1'b1, 32'h80, 32'h55);
        step(); clr_in();
        chk("sim_req_valid", mem_req_valid_o, 1);
        chk("sim_req_addr", mem_req_addr_o, 32'h80);
        chk("sim_req_we", mem_req_we_o, 1);
        chk("sim_req_wdata", mem_req_wdata_o, 32'h55);
        chk("sim_busy1", d_busy_o, 1);
        step();
        mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'h9;
        chk("sim_busy2", d_busy_o, 1);
        step(); clr_in();
        chk("sim_d_resp_valid", d_resp_valid_o, 1);
        chk("sim_d_resp_data", d_resp_data_o, 0);
        chk("sim_busy3", d_busy_o, 1);
        chk("sim_no_fetch_yet", mem_req_valid_o, 0);
        step();
        chk("sim_fetch_valid", mem_req_valid_o, 1);
        chk("sim_fetch_addr", mem_req_addr_o, 32'h20);
        chk("sim_fetch_we", mem_req_we_o, 0);
        chk("sim_busy4", d_busy_o, 0);
        mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'hABCD;
        step(); clr_in();
        chk("sim_if_resp", if_resp_valid_o, 1);
        chk("sim_if_data", if_resp_data_o, 32'hABCD);
        step();

        // Starvation limit, twice: the second round shows the counter restarted at 0.
        starve_round(nd, fwe);
        chk("starve1_data_grants", nd, SL);
        chk("starve1_fetch_we", fwe, 0);
        starve_round(nd, fwe);
        chk("starve2_data_grants", nd, SL);

        // Response and new data request in the same cycle.
        pulse_d(1'b0, 32'h300, 32'h0);
        step(); clr_in();
        chk("b2b_req1", mem_req_valid_o, 1);
        step();
        mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'hCAFE0001;
        pulse_d(1'b0, 32'h304, 32'h0);
        step(); clr_in();
        chk("b2b_resp1_valid", d_resp_valid_o, 1);
        chk("b2b_resp1_data", d_resp_data_o, 32'hCAFE0001);
        chk("b2b_req2_not_yet", mem_req_valid_o, 0);
        chk("b2b_busy", d_busy_o, 1);
        step();
        chk("b2b_req2_valid", mem_req_valid_o, 1);
        chk("b2b_req2_addr", mem_req_addr_o, 32'h304);
        mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'h0BAD;
        step(); clr_in();
        chk("b2b_resp2_data", d_resp_data_o, 32'h0BAD);
        step();

        // Randomized traffic against the transaction-level model.
        m_free = 1; w_if = 0; w_d = 0; starve = 0; owner = 0; dflag = 0;
        e_req_v = 0; e_ifr = 0; e_dr = 0; e_busy = 0;
        if_out = 0; d_out = 0; mem_pend = 0; mem_cnt = 0;
        owner_we = 0; e_rdata = 0; e_req_we = 0; e_req_addr = 0; e_req_wdata = 0;
        e_req_size = SIZE_BYTE;
        for (int c = 0; c < 3000; c++) begin
            step();
            chk("rnd_req_valid", mem_req_valid_o, e_req_v);
            if (e_req_v) begin
                chk("rnd_req_addr", mem_req_addr_o, e_req_addr);
                chk("rnd_req_we", mem_req_we_o, e_req_we);
                chk("rnd_req_size", mem_req_size_o, e_req_size);
                if (e_req_we) chk("rnd_req_wdata", mem_req_wdata_o, e_req_wdata);
            end
            chk("rnd_if_resp_valid", if_resp_valid_o, e_ifr);
            chk("rnd_d_resp_valid", d_resp_valid_o, e_dr);
            if (e_ifr) chk("rnd_if_resp_data", if_resp_data_o, e_rdata);
            if (e_dr)  chk("rnd_d_resp_data", d_resp_data_o, e_rdata);
            chk("rnd_d_busy", d_busy_o, e_busy);
            if (e_ifr) if_out = 0;
            if (e_dr)  d_out = 0;

            clr_in();
            a_if = 0; a_d = 0; resp_now = 0;
            if (e_req_v) begin mem_pend = 1; mem_cnt = $urandom_range(0, 3); end
            if (mem_pend) begin
                if (mem_cnt == 0) begin
                    mem_resp_valid_i = 1'b1; mem_resp_data_i = $urandom; mem_pend = 0; resp_now = 1;
                end else mem_cnt--;
            end
            if (!if_out && $urandom_range(0, 3) == 0) begin
                if_req_valid_i = 1'b1; if_req_addr_i = $urandom;
                if_req_size_i = access_size_t'($urandom_range(0, 2));
                if_out = 1; a_if = 1;
            end
            if (!d_out && $urandom_range(0, 2) == 0) begin
                d_req_valid_i = 1'b1; d_req_we_i = $urandom_range(0, 1); d_req_addr_i = $urandom;
                d_req_wdata_i = $urandom; d_req_size_i = access_size_t'($urandom_range(0, 2));
                d_out = 1; a_d = 1;
            end

            // Advance the model to the next cycle.
            if (e_dr) dflag = 0;
            if (a_d)  dflag = 1;
            e_ifr = 0; e_dr = 0; e_req_v = 0;
            if (resp_now) begin
                if (owner == 1) begin e_ifr = 1; e_rdata = mem_resp_data_i; end
                else begin e_dr = 1; e_rdata = owner_we ? 32'h0 : mem_resp_data_i; end
                owner = 0;
            end
            if (a_if) begin w_if = 1; w_if_addr = if_req_addr_i; w_if_size = if_req_size_i; end
            if (a_d) begin
                w_d = 1; w_d_we = d_req_we_i; w_d_addr = d_req_addr_i;
                w_d_wdata = d_req_wdata_i; w_d_size = d_req_size_i;
            end
            if (m_free && (w_if || w_d)) begin
                e_req_v = 1; m_free = 0;
                if (w_if && (!w_d || starve == SL)) begin
                    e_req_we = 0; e_req_addr = w_if_addr; e_req_size = w_if_size;
                    w_if = 0; starve = 0; owner = 1;
                end else begin
                    e_req_we = w_d_we; e_req_addr = w_d_addr; e_req_wdata = w_d_wdata;
                    e_req_size = w_d_size; owner_we = w_d_we;
                    if (w_if) starve = (starve < SL) ? starve + 1 : SL;
                    w_d = 0; owner = 2;
                end
            end
            if (resp_now) m_free = 1;
            e_busy = dflag;
        end
        clr_in();
        chk("rnd_no_spurious", spurious_o, 0);
        rst_i = 1'b0; #2; rst_i = 1'b1;
        step();

        // Reset mid-store, then a stray response.
        pulse_d(1'b1, 32'h500, 32'h1234);
        step(); clr_in();
        chk("rst_req_valid", mem_req_valid_o, 1);
        rst_i = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        #1;
        rst_i = 1'b1;
        step();
        mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'h4444;
        step(); clr_in();
        chk("rst_no_d_resp", d_resp_valid_o, 0);
        chk("rst_spurious", spurious_o, 1);
        step();
        chk("rst_spurious_sticky", spurious_o, 1);
        chk("rst_no_req", mem_req_valid_o, 0);
        rst_i = 1'b0;
        #1;
        chk("rst_spurious_clr", spurious_o, 0);
        rst_i = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
